riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
- Shares one single-port memory bus between the RISCV core's instruction-fetch port and its data (load/store) port.
- Accepts one request at a time, forwards it to memory using a req/gnt/rvalid handshake, and returns the response to the owning requester.
- Arbitration is data-priority with a fetch starvation guard.
- A per-transaction timeout guarantees forward progress if memory hangs.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
MAX_CONSEC, 4, max back-to-back data grants while fetch is pending before fetch is forced
TIMEOUT, 255, cycles allowed in REQ+WAIT before an error response (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  fetch response valid (1-cycle pulse)
if_rdata  out  DATA_WIDTH  fetch read data
if_err  out  1  fetch response is a timeout error
d_req  in  1  data request
d_we  in  1  1=write, 0=read
d_be  in  DATA_WIDTH/8  byte enables
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  write data
d_gnt  out  1  data request accepted
d_rvalid  out  1  data response valid
d_rdata  out  DATA_WIDTH  data read data (0 for writes)
d_err  out  1  data response is a timeout error
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  DATA_WIDTH/8  memory byte enables
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response valid
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset: clk rising edge with reset=1 forces the following:
  - state=IDLE; consec counter and timeout counter = 0.
  - All outputs 0, including the latched mem_* fields and the rdata registers.
  - An in-flight transaction is dropped silently: no rvalid is ever produced for it.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any req is high, arbitrate, latch the winner's fields (fetch: we=0, be=all ones, wdata=0), and record the owner.
  - Pulse the owner's gnt combinationally in the same cycle. The requester may drop req after gnt.
  - Next state REQ. No request: stay in IDLE.
- Arbitration:
  - d_req alone wins; if_req alone wins.
  - Both high: data wins unless consec==MAX_CONSEC, in which case fetch wins.
  - consec increments (saturating at MAX_CONSEC) on each data grant made while if_req=1.
  - consec clears on every fetch grant.
  - consec is unchanged by a data grant made while if_req=0.
- REQ:
  - mem_req=1 with the latched fields, held stable until mem_gnt=1.
  - On mem_gnt=1 go to WAIT; mem_req is 0 from the next cycle.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1: register the response and go to IDLE.
  - The response register takes mem_rdata for reads and 0 for writes.
- Response:
  - Next cycle after mem_rvalid, the owner's rvalid=1 for exactly one cycle, with rdata valid and err=0.
  - rdata holds its value until the next response to that port.
  - The non-owner's rvalid stays 0.
  - A new grant may occur in the same cycle as the rvalid pulse.
- Latency: req to gnt is 0 cycles. gnt to mem_req is 1 cycle. mem_rvalid to port rvalid is 1 cycle.
- Timeout:
  - The counter clears on REQ entry and increments every cycle in REQ or WAIT.
  - If TIMEOUT cycles elapse without mem_rvalid, go to IDLE.
  - Next cycle: owner rvalid=1, err=1, rdata=0.
  - mem_rvalid arriving in the same cycle as expiry takes precedence: normal response.
- Ignored inputs:
  - mem_rvalid in IDLE or REQ is ignored.
  - mem_gnt outside REQ is ignored.
- Only one transaction is outstanding; no pipelining.
- busy=1 in REQ and WAIT.

Test Plan:
1. Fetch read:
   - Stimulus: if_req=1, if_addr=0x0040_0000; mem_gnt in the first REQ cycle; mem_rvalid 2 cycles later with mem_rdata=0xDEAD_BEEF.
   - Required: if_gnt at cycle 0; mem_req/mem_addr=0x0040_0000 at cycle 1; if_rvalid=1, if_rdata=0xDEAD_BEEF, if_err=0 one cycle after mem_rvalid; d_rvalid stays 0.
2. Contention:
   - Stimulus: if_req and d_req held high continuously; memory responds each transaction.
   - Required: grant order D,D,D,D,I,D,D,D,D,I.
3. Data write:
   - Stimulus: d_we=1, d_be=4'b0011, d_addr=0x1000_0024, d_wdata=0x0000_00A5.
   - Required: mem_* carry exactly those values while mem_req=1; d_rvalid=1, d_rdata=0, d_err=0.
4. Timeout:
   - Stimulus: TIMEOUT=8, data read, mem_gnt held 0.
   - Required: mem_req drops after 8 REQ cycles; next cycle d_rvalid=1, d_err=1, d_rdata=0; a later stray mem_rvalid causes no output.
5. Reset in WAIT:
   - Stimulus: assert reset for 1 cycle while in WAIT.
   - Required: next cycle busy=0 and all outputs 0; no rvalid for the dropped transaction; a following fetch completes normally.
6. Stray response in IDLE:
   - Stimulus: mem_rvalid=1 with no transaction active.
   - Required: no rvalid on either port, state stays IDLE.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data ports.
// Data has priority, with a fetch starvation guard and a per-transaction timeout.
module riscv_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CW   = $clog2(MAX_CONSEC + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         consec_q, consec_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  owner_d_q, owner_d_d;
    logic                  mem_we_q, mem_we_d;
    logic [BE_W-1:0]       mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_err_q, if_err_d;
    logic                  d_err_q, d_err_d;

    logic                  starved;
    logic                  win_d;
    logic                  win_i;
    logic                  expire;
    logic                  resp_fire;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;

    always_comb begin
        state_d     = state_q;
        consec_d    = consec_q;
        tmo_d       = tmo_q;
        owner_d_d   = owner_d_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_err_d    = if_err_q;
        d_err_d     = d_err_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        resp_fire   = 1'b0;
        resp_err    = 1'b0;
        resp_data   = '0;

        starved = if_req && (consec_q == CW'(MAX_CONSEC));
        win_d   = d_req && !starved;
        win_i   = if_req && !win_d;
        expire  = (tmo_q == TW'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (win_d) begin
                    d_gnt       = 1'b1;
                    owner_d_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (if_req && (consec_q != CW'(MAX_CONSEC))) begin
                        consec_d = consec_q + 1'b1;
                    end
                    tmo_d   = '0;
                    state_d = REQ;
                end else if (win_i) begin
                    if_gnt      = 1'b1;
                    owner_d_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    consec_d    = '0;
                    tmo_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                tmo_d = tmo_q + 1'b1;
                if (expire) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = IDLE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // a response arriving on the expiry cycle still counts as normal
                if (mem_rvalid) begin
                    resp_fire = 1'b1;
                    resp_data = mem_we_q ? '0 : mem_rdata;
                    state_d   = IDLE;
                end else if (expire) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resp_fire) begin
            if (owner_d_q) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = resp_data;
                d_err_d    = resp_err;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = resp_data;
                if_err_d    = resp_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            consec_q    <= '0;
            tmo_q       <= '0;
            owner_d_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            consec_q    <= consec_d;
            tmo_q       <= tmo_d;
            owner_d_q   <= owner_d_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign busy      = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: expectations queued at grant, checked at rvalid.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    riscv_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_CONSEC(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    byte         grants[$];
    int          checks = 0;
    int          errors = 0;
    int          rv_dly = 2;
    logic        mem_hang = 1'b0;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr = '0;
    logic        exp_err = 1'b0;
    int          stray_cnt = 0;
    int          stray_done = 0;
    string       exp_s = "DDDDIDDDDI";

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic issue_fetch(input logic [31:0] a);
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = a;
        @(negedge clk);
        check_eq("if_gnt_lat", 32'(if_gnt), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic issue_data(input logic we, input logic [3:0] be,
                              input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        @(negedge clk);
        check_eq("d_gnt_lat", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check_eq("drain_busy", 32'(busy), 32'd0);
        check_eq("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        fork
            // memory responder: grants immediately, answers rv_dly cycles later
            begin
                logic        l_we;
                logic [31:0] l_addr;
                forever begin
                    @(posedge clk); #2;
                    mem_gnt    = 1'b0;
                    mem_rvalid = 1'b0;
                    if (stray_cnt != stray_done) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = 32'hFFFF_0000;
                        stray_done++;
                    end else if (mem_req && !mem_hang) begin
                        mem_gnt = 1'b1;
                        l_we    = mem_we;
                        l_addr  = mem_addr;
                        @(posedge clk); #2;
                        mem_gnt = 1'b0;
                        for (int k = 1; k < rv_dly; k++) begin
                            @(posedge clk); #2;
                        end
                        mem_rvalid = 1'b1;
                        mem_rdata  = l_we ? 32'hBAD0_BAD0 : (rd_ovr_en ? rd_ovr : mem_fn(l_addr));
                    end
                end
            end
            // monitor / scoreboard
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!reset) begin
                        if (sb.size() == 0) begin
                            check_eq("no_rv", {30'd0, if_rvalid, d_rvalid}, 32'd0);
                        end else if (if_rvalid || d_rvalid) begin
                            e = sb.pop_front();
                            check_eq("rv_port", {30'd0, if_rvalid, d_rvalid}, e.is_d ? 32'd1 : 32'd2);
                            check_eq("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                            check_eq("err", 32'(e.is_d ? d_err : if_err), 32'(e.err));
                        end
                        if (mem_req) begin
                            if (sb.size() == 0) begin
                                check_eq("mem_req_orphan", 32'(mem_req), 32'd0);
                            end else begin
                                check_eq("mem_addr", mem_addr, sb[0].addr);
                                check_eq("mem_we", 32'(mem_we), 32'(sb[0].we));
                                check_eq("mem_be", 32'(mem_be), 32'(sb[0].be));
                                check_eq("mem_wdata", mem_wdata, sb[0].wdata);
                            end
                        end
                        if (d_gnt || if_gnt) begin
                            e.is_d  = d_gnt;
                            e.we    = d_gnt ? d_we : 1'b0;
                            e.be    = d_gnt ? d_be : 4'hF;
                            e.addr  = d_gnt ? d_addr : if_addr;
                            e.wdata = d_gnt ? d_wdata : 32'd0;
                            e.err   = exp_err;
                            e.rdata = (exp_err || e.we) ? 32'd0 :
                                      (rd_ovr_en ? rd_ovr : mem_fn(e.addr));
                            sb.push_back(e);
                            grants.push_back(d_gnt ? "D" : "I");
                        end
                    end
                end
            end
            // stimulus
            begin
                int n;
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_mem_req", 32'(mem_req), 32'd0);
                check_eq("rst_rv", {30'd0, if_rvalid, d_rvalid}, 32'd0);
                check_eq("rst_rdata", if_rdata | d_rdata, 32'd0);

                // fetch read
                rv_dly    = 2;
                rd_ovr_en = 1'b1;
                rd_ovr    = 32'hDEAD_BEEF;
                issue_fetch(32'h0040_0000);
                @(negedge clk);
                check_eq("t1_mem_req", 32'(mem_req), 32'd1);
                check_eq("t1_mem_addr", mem_addr, 32'h0040_0000);
                for (n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (mem_rvalid) break;
                end
                @(negedge clk);
                check_eq("t1_if_rvalid", 32'(if_rvalid), 32'd1);
                check_eq("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
                check_eq("t1_d_rvalid", 32'(d_rvalid), 32'd0);
                wait_idle(20);
                rd_ovr_en = 1'b0;

                // contention
                grants.delete();
                rv_dly = 1;
                @(posedge clk); #1;
                if_req  = 1'b1;
                if_addr = 32'h0000_0100;
                d_req   = 1'b1;
                d_we    = 1'b0;
                d_be    = 4'hF;
                d_addr  = 32'h0000_0800;
                d_wdata = 32'h1111_2222;
                for (n = 0; n < 400; n++) begin
                    @(negedge clk);
                    if (grants.size() >= 10) break;
                end
                @(posedge clk); #1;
                if_req = 1'b0;
                d_req  = 1'b0;
                check_eq("order_len", 32'(grants.size()), 32'd10);
                for (int i = 0; i < 10 && i < grants.size(); i++) begin
                    check_eq("order", 32'(grants[i]), 32'(exp_s[i]));
                end
                wait_idle(40);

                // data write
                issue_data(1'b1, 4'b0011, 32'h1000_0024, 32'h0000_00A5);
                wait_idle(20);
                check_eq("t3_d_rdata", d_rdata, 32'd0);
                check_eq("t3_d_err", 32'(d_err), 32'd0);

                // timeout
                mem_hang = 1'b1;
                exp_err  = 1'b1;
                issue_data(1'b0, 4'hF, 32'h2000_0040, 32'd0);
                exp_err = 1'b0;
                n = 0;
                @(negedge clk);
                while (mem_req && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                check_eq("t4_req_cycles", 32'(n), 32'd8);
                check_eq("t4_d_rvalid", 32'(d_rvalid), 32'd1);
                check_eq("t4_d_err", 32'(d_err), 32'd1);
                check_eq("t4_d_rdata", d_rdata, 32'd0);
                mem_hang = 1'b0;
                stray_cnt++;
                repeat (4) @(negedge clk);
                check_eq("t4_busy", 32'(busy), 32'd0);
                wait_idle(10);

                // reset in WAIT
                rv_dly = 6;
                issue_data(1'b1, 4'b1010, 32'h3000_0010, 32'h1234_5678);
                @(posedge clk); #1;
                check_eq("t5_busy_pre", 32'(busy), 32'd1);
                reset = 1'b1;
                sb.delete();
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check_eq("t5_busy", 32'(busy), 32'd0);
                check_eq("t5_mem_req", 32'(mem_req), 32'd0);
                check_eq("t5_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
                check_eq("t5_mem_addr", mem_addr, 32'd0);
                check_eq("t5_mem_wdata", mem_wdata, 32'd0);
                check_eq("t5_rdata", if_rdata | d_rdata, 32'd0);
                check_eq("t5_flags", {28'd0, if_rvalid, d_rvalid, if_err, d_err}, 32'd0);
                repeat (10) @(negedge clk);
                rv_dly = 3;
                issue_fetch(32'h0040_0010);
                wait_idle(20);
                check_eq("t5_if_rdata", if_rdata, mem_fn(32'h0040_0010));

                // stray response in IDLE
                stray_cnt++;
                repeat (4) @(negedge clk);
                check_eq("t6_busy", 32'(busy), 32'd0);
                check_eq("t6_rv", {30'd0, if_rvalid, d_rvalid}, 32'd0);
                wait_idle(5);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
